// File: rtl/vga_tile_pkg.sv
// Shared types for the background tile-map update path.
//   tile_code_t   : tile codes held in the 12x17 background map
//   tile_update_t : one pending map write {row, col, tile}
//   sched_state_t : vblank drain controller states
package vga_tile_pkg;

  localparam int ROWS        = 12;
  localparam int COLS        = 17;
  localparam int BLOCK_WIDTH = 32;   // tile edge in pixels as drawn by the VGA environment drawer

  localparam int ROW_W  = 4;
  localparam int COL_W  = 5;
  localparam int TILE_W = 8;

  typedef enum byte {
    BDR = 8'd0,
    SKY = 8'd1,
    BLK = 8'd2,
    GND = 8'd3,
    TKN = 8'd4,
    CK1 = 8'd5,
    CK2 = 8'd6
  } tile_code_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [TILE_W-1:0] tile;
  } tile_update_t;

  localparam int UPD_W = $bits(tile_update_t);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tile_update_fifo.sv
// Synchronous FIFO of pending tile-map updates (show-ahead head output).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one update (ignored when full)
//   pop               retire the head entry (ignored when empty)
//   head              current head entry
//   level             entries held, 0..DEPTH (registered)
//   full, empty       registered status flags
module tile_update_fifo
  import vga_tile_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [UPD_W-1:0]         push_data,
  input  logic                     pop,
  output logic [UPD_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UPD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    level_d = level;
    if (do_push && !do_pop) level_d = level + 1'b1;
    else if (do_pop && !do_push) level_d = level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_d;
      full  <= (level_d == (AW+1)'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tile_update_scheduler.sv
// Serialises tile-map update requests from N_REQ requesters onto the single
// tile-map write port; writes are committed only during vertical blanking.
// Optional feature macro: TILE_SCHED_STATS_EN (adds frame_writes/frame_deferred).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req[N_REQ]                   request per requester, held until ack
//   req_row/req_col/req_tile     flattened per-requester address/data (requester i at slice i)
//   ack[N_REQ]                   one-hot 1-cycle accept pulse (also for discarded OOB requests)
//   vblank                       vertical blanking from VGA timing
//   tile_we, tile_row/col/data   tile-map write port
//   busy, fifo_level             FIFO non-empty, entries pending
//   err_oob                      1-cycle pulse with ack when the accepted request was off-map
//   frame_writes/frame_deferred  (stats build) writes and leftovers of the last vblank
//
// state    | meaning
// ST_WAIT  | waiting for a vblank rising edge
// ST_DRAIN | vblank active, popping one entry per cycle
// ST_DONE  | FIFO emptied this vblank; later pushes wait for the next frame
module tile_update_scheduler
  import vga_tile_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ROW_W-1:0]    req_row,
  input  logic [N_REQ*COL_W-1:0]    req_col,
  input  logic [N_REQ*TILE_W-1:0]   req_tile,
  output logic [N_REQ-1:0]          ack,
  input  logic                      vblank,
  output logic                      tile_we,
  output logic [ROW_W-1:0]          tile_row,
  output logic [COL_W-1:0]          tile_col,
  output logic [TILE_W-1:0]         tile_data,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      err_oob
`ifdef TILE_SCHED_STATS_EN
  ,
  output logic [7:0]                frame_writes,
  output logic [7:0]                frame_deferred
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t     state_q, state_d;
  logic             vblank_q;
  logic             rise;
  logic             pop;
  logic [IDX_W-1:0] rr_q;
  logic [N_REQ-1:0] elig;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  tile_update_t     sel_upd;
  logic             oob;
  logic             push;
  tile_update_t     fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pend_vld_q;
  tile_update_t     pend_q;

  // A requester whose ack is showing this cycle is still holding req; it is
  // masked so one handshake produces exactly one entry.
  always_comb begin
    elig      = req & ~ack;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_vld && elig[(int'(rr_q) + i) % N_REQ]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'((int'(rr_q) + i) % N_REQ);
        end
      end
    end
  end

  always_comb begin
    sel_upd.row  = req_row[int'(grant_idx)*ROW_W +: ROW_W];
    sel_upd.col  = req_col[int'(grant_idx)*COL_W +: COL_W];
    sel_upd.tile = req_tile[int'(grant_idx)*TILE_W +: TILE_W];
  end

  assign oob  = (sel_upd.row >= ROW_W'(ROWS)) || (sel_upd.col >= COL_W'(COLS));
  assign push = grant_vld & ~oob;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q    <= '0;
      ack     <= '0;
      err_oob <= 1'b0;
    end else begin
      ack     <= grant_vld ? (N_REQ'(1) << grant_idx) : '0;
      err_oob <= grant_vld & oob;
      if (grant_vld)
        rr_q <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  tile_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (sel_upd),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy = ~fifo_empty;

  // vblank_q resets high so a vblank already active when reset releases is
  // not mistaken for a rising edge.
  assign rise = vblank & ~vblank_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT;
      vblank_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (rise) state_d = fifo_empty ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!vblank)         state_d = ST_WAIT;
        else if (fifo_empty) state_d = ST_DONE;
        else                 pop     = 1'b1;
      end
      ST_DONE: begin
        if (!vblank) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Popped entry is staged one cycle before it drives the write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      tile_we    <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
      tile_data  <= '0;
    end else begin
      pend_vld_q <= pop;
      if (pop) pend_q <= fifo_head;
      tile_we <= pend_vld_q;
      if (pend_vld_q) begin
        tile_row  <= pend_q.row;
        tile_col  <= pend_q.col;
        tile_data <= pend_q.tile;
      end
    end
  end

`ifdef TILE_SCHED_STATS_EN
  logic       fall;
  logic [7:0] wr_cnt_q;

  assign fall = vblank_q & ~vblank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q       <= '0;
      frame_writes   <= '0;
      frame_deferred <= '0;
    end else if (fall) begin
      frame_writes   <= wr_cnt_q;
      frame_deferred <= (int'(fifo_level) > 255) ? 8'hFF : 8'(fifo_level);
      wr_cnt_q       <= '0;
    end else if (pop && wr_cnt_q != 8'hFF) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end
`endif

endmodule
